// File: rtl/shift_align_pipe_pkg.sv
// Shared types and helpers for the shift/align pipeline.
//   shift_dir_e   : shift direction carried between stages
//   COARSE_STEP   : granularity of the first-stage shift
//   clog2         : elaboration-time ceiling log2
//   exp_in_range  : legal-exponent check for a raw EXP_W-bit two's-complement value
package shift_align_pkg;

  typedef enum logic {
    SH_LEFT  = 1'b0,
    SH_RIGHT = 1'b1
  } shift_dir_e;

  localparam int unsigned COARSE_STEP = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // raw holds the exponent in its low exp_w bits; it is sign-extended here.
  function automatic logic exp_in_range(input logic [31:0] raw, input int unsigned exp_w,
                                        input int max_l, input int max_r);
    int e;
    e = int'(raw << (32 - exp_w)) >>> (32 - exp_w);
    return (e <= max_l) && (e >= -max_r);
  endfunction

endpackage

// File: rtl/shift_align_pipe_if.sv
// Stream bundle for shift_align_pipe.
//   in_valid/in_ready/in_data/in_exp            : upstream beat (mantissa + signed exponent)
//   out_valid/out_ready/out_data/out_ovf/
//   out_sticky/out_range                        : downstream aligned beat and flags
// slave = the aligner's view, master = the surrounding datapath's view.
interface shift_align_pipe_if #(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 23,
  parameter int unsigned EXP_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_sticky;
  logic             out_range;

  modport slave (
    input  in_valid, in_data, in_exp, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_sticky, out_range
  );

  modport master (
    output in_valid, in_data, in_exp, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_sticky, out_range
  );
endinterface

// File: rtl/shift_align_pipe_stage.sv
// One registered shift slice: shifts data_in by amt_in*STEP in direction dir_in,
// ORs bits lost off the top (left) into ovf and off the bottom (right) into sticky,
// and carries SIDE_W bits of sideband alongside. Registers load only when en=1.
//   OVF_LSB : result bit positions >= OVF_LSB count as overflow on a left shift
//   OUT_DW  : registered data width (low bits of the shifted result)
module shift_align_stage
  import shift_align_pkg::*;
#(
  parameter int unsigned DW      = 26,
  parameter int unsigned OUT_DW  = 26,
  parameter int unsigned STEP    = 1,
  parameter int unsigned AMT_W   = 2,
  parameter int unsigned OVF_LSB = 26,
  parameter int unsigned SIDE_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  shift_dir_e        dir_in,
  input  logic [AMT_W-1:0]  amt_in,
  input  logic [DW-1:0]     data_in,
  input  logic              ovf_in,
  input  logic              sticky_in,
  input  logic [SIDE_W-1:0] side_in,
  output logic [OUT_DW-1:0] data_out,
  output logic              ovf_out,
  output logic              sticky_out,
  output logic [SIDE_W-1:0] side_out
);

  int unsigned       sh;
  logic [2*DW-1:0]   wide_l;
  logic [2*DW-1:0]   wide_r;
  logic [OUT_DW-1:0] nxt_data;
  logic              nxt_ovf;
  logic              nxt_sticky;

  // Double-width shifts keep every displaced bit visible for flag accumulation.
  always_comb begin
    sh         = 32'(amt_in) * STEP;
    wide_l     = {{DW{1'b0}}, data_in} << sh;
    wide_r     = {data_in, {DW{1'b0}}} >> sh;
    nxt_data   = '0;
    nxt_ovf    = ovf_in;
    nxt_sticky = sticky_in;
    if (dir_in == SH_LEFT) begin
      nxt_data = OUT_DW'(wide_l);
      nxt_ovf  = ovf_in | (|(wide_l >> OVF_LSB));
    end else begin
      nxt_data   = OUT_DW'(wide_r >> DW);
      nxt_sticky = sticky_in | (|(DW'(wide_r)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      ovf_out    <= 1'b0;
      sticky_out <= 1'b0;
      side_out   <= '0;
    end else if (en) begin
      data_out   <= nxt_data;
      ovf_out    <= nxt_ovf;
      sticky_out <= nxt_sticky;
      side_out   <= side_in;
    end
  end

endmodule

// File: rtl/shift_align_pipe.sv
// Two-stage mantissa aligner: shifts an unsigned IN_W-bit mantissa left (e>0) or
// right (e<0) by a signed exponent, reporting overflow, sticky and out-of-range.
// Out-of-range exponents pass the mantissa through unshifted with only range set.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : valid/ready stream (see shift_align_pipe_if), slave side
// S1 = decode + coarse shift (multiples of COARSE_STEP), S2 = fine shift + outputs.
module shift_align_pipe
  import shift_align_pkg::*;
#(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned OUT_W = 23,
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAX_L = 3,
  parameter int unsigned MAX_R = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_align_pipe_if.slave   bus
);

  localparam int unsigned WW   = OUT_W + MAX_L;
  localparam int unsigned FA_W = clog2(COARSE_STEP);
  localparam int unsigned CA_W = EXP_W + 1 - FA_W;
  localparam int unsigned SD_W = FA_W + 2;

  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s1_load;
  logic                    s2_load;
  logic                    in_fire;

  logic signed [EXP_W:0]   e_ext;
  logic [EXP_W:0]          mag;
  logic                    range;
  shift_dir_e              dir;

  logic [WW-1:0]           c_data;
  logic                    c_ovf;
  logic                    c_sticky;
  logic [SD_W-1:0]         c_side;

  logic [OUT_W-1:0]        f_data;
  logic                    f_ovf;
  logic                    f_sticky;
  logic                    f_range;

  // Out-of-range beats take a zero shift, so they emerge unshifted with clean flags.
  always_comb begin
    e_ext = {bus.in_exp[EXP_W-1], bus.in_exp};
    range = !exp_in_range(32'(bus.in_exp), EXP_W, int'(MAX_L), int'(MAX_R));
    dir   = SH_LEFT;
    mag   = '0;
    if (!range) begin
      if (e_ext < 0) begin
        dir = SH_RIGHT;
        mag = $unsigned(-e_ext);
      end else begin
        mag = $unsigned(e_ext);
      end
    end
  end

  // in_ready is the S1 load condition; it reduces to ~s1_valid | ~s2_valid | out_ready.
  assign s2_load      = ~s2_valid | bus.out_ready;
  assign s1_load      = ~s1_valid | s2_load;
  assign in_fire      = bus.in_valid & s1_load;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (s2_load) s2_valid <= s1_valid;
    end
  end

  shift_align_stage #(
    .DW      (WW),
    .OUT_DW  (WW),
    .STEP    (COARSE_STEP),
    .AMT_W   (CA_W),
    .OVF_LSB (WW),
    .SIDE_W  (SD_W)
  ) u_coarse (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (in_fire),
    .dir_in     (dir),
    .amt_in     (mag[EXP_W:FA_W]),
    .data_in    (WW'(bus.in_data)),
    .ovf_in     (1'b0),
    .sticky_in  (1'b0),
    .side_in    ({mag[FA_W-1:0], dir, range}),
    .data_out   (c_data),
    .ovf_out    (c_ovf),
    .sticky_out (c_sticky),
    .side_out   (c_side)
  );

  shift_align_stage #(
    .DW      (WW),
    .OUT_DW  (OUT_W),
    .STEP    (1),
    .AMT_W   (FA_W),
    .OVF_LSB (OUT_W),
    .SIDE_W  (1)
  ) u_fine (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (s2_load & s1_valid),
    .dir_in     (shift_dir_e'(c_side[1])),
    .amt_in     (c_side[SD_W-1:2]),
    .data_in    (c_data),
    .ovf_in     (c_ovf),
    .sticky_in  (c_sticky),
    .side_in    (c_side[0]),
    .data_out   (f_data),
    .ovf_out    (f_ovf),
    .sticky_out (f_sticky),
    .side_out   (f_range)
  );

  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = f_data;
  assign bus.out_ovf    = f_ovf;
  assign bus.out_sticky = f_sticky;
  assign bus.out_range  = f_range;

endmodule

// File: tb/tb_shift_align_pipe.sv
module tb_shift_align_pipe;

  typedef struct packed {
    logic [22:0] data;
    logic        ovf;
    logic        sticky;
    logic        range;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  shift_align_pipe_if #(.IN_W(20), .OUT_W(23), .EXP_W(5)) bus ();
  shift_align_pipe_if #(.IN_W(20), .OUT_W(21), .EXP_W(5)) bus_n ();

  shift_align_pipe #(.IN_W(20), .OUT_W(23), .EXP_W(5), .MAX_L(3), .MAX_R(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  shift_align_pipe #(.IN_W(20), .OUT_W(21), .EXP_W(5), .MAX_L(3), .MAX_R(12)) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  function automatic beat_t model(input logic [19:0] d, input logic [4:0] e);
    beat_t r;
    int ei;
    longint unsigned w;
    r  = '0;
    ei = int'($signed(e));
    if (ei > 3 || ei < -12) begin
      r.data  = 23'(d);
      r.range = 1'b1;
    end else if (ei >= 0) begin
      w     = 64'(d) << ei;
      r.data = 23'(w);
      r.ovf  = (w >> 23) != 0;
    end else begin
      r.data   = 23'(d >> (-ei));
      r.sticky = (d & 20'((1 << (-ei)) - 1)) != 0;
    end
    return r;
  endfunction

  // One cycle on the default-width DUT: drive at negedge, sample 1ns later.
  task automatic drive_cycle(input logic iv, input logic [19:0] d, input logic [4:0] e,
                             input logic ordy, input beat_t want,
                             output logic acc, output logic rdy, output logic popped,
                             output beat_t obs);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_exp    = e;
    bus.out_ready = ordy;
    #1;
    rdy    = bus.in_ready;
    acc    = iv && bus.in_ready;
    if (acc) sb.push_back(want);
    popped = bus.out_valid && ordy;
    obs    = {bus.out_data, bus.out_ovf, bus.out_sticky, bus.out_range};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if ({bus.out_data, bus.out_ovf, bus.out_sticky, bus.out_range} !== 26'h0)
      $display("FAIL reset_outputs: got data=%h ovf=%b sticky=%b range=%b want all 0",
               bus.out_data, bus.out_ovf, bus.out_sticky, bus.out_range);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_left();
    logic [19:0] d[2];
    beat_t w[2];
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    int idx = 0, k, acc_cyc = -1, pop_cyc = -1;
    d[0] = 20'h80001; w[0] = '{data: 23'h400008, ovf: 1'b0, sticky: 1'b0, range: 1'b0};
    d[1] = 20'hFFFFF; w[1] = '{data: 23'h7FFFF8, ovf: 1'b0, sticky: 1'b0, range: 1'b0};
    for (int c = 0; c < 20; c++) begin
      k = (idx < 2) ? idx : 1;
      drive_cycle(idx < 2, d[k], 5'd3, 1'b1, w[k], acc, rdy, popped, obs);
      if (acc) begin
        if (acc_cyc < 0) acc_cyc = c;
        idx++;
      end
      if (popped) begin
        if (pop_cyc < 0) pop_cyc = c;
        n_checks++;
        if (sb.size() == 0) $display("FAIL left_extra: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL left: got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (idx == 2 && sb.size() == 0) break;
    end
    n_checks++;
    if (pop_cyc - acc_cyc !== 2) $display("FAIL left_latency: got %0d want 2", pop_cyc - acc_cyc);
    else n_pass++;
    n_checks++;
    if (idx != 2 || sb.size() != 0) $display("FAIL left_drain: accepted %0d want 2, pending %0d want 0", idx, sb.size());
    else n_pass++;
  endtask

  task automatic test_left_narrow();
    logic seen = 1'b0;
    @(negedge clk);
    bus_n.in_valid  = 1'b1;
    bus_n.in_data   = 20'hFFFFF;
    bus_n.in_exp    = 5'd3;
    bus_n.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus_n.in_ready !== 1'b1) $display("FAIL narrow_ready: got %b want 1", bus_n.in_ready);
    else n_pass++;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      bus_n.in_valid = 1'b0;
      #1;
      if (bus_n.out_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if ({bus_n.out_data, bus_n.out_ovf, bus_n.out_sticky, bus_n.out_range} !== {21'h1FFFF8, 3'b100})
          $display("FAIL narrow_left: got data=%h ovf=%b sticky=%b range=%b want data=1ffff8 ovf=1 sticky=0 range=0",
                   bus_n.out_data, bus_n.out_ovf, bus_n.out_sticky, bus_n.out_range);
        else n_pass++;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL narrow_timeout: got no output want one beat");
    else n_pass++;
  endtask

  task automatic test_right();
    logic [19:0] d[4];
    logic [4:0]  e[4];
    beat_t w[4];
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    int idx = 0, k;
    d[0] = 20'hABCDE; e[0] = 5'b11100; w[0] = '{data: 23'h0ABCD, ovf: 1'b0, sticky: 1'b1, range: 1'b0};
    d[1] = 20'hABCD0; e[1] = 5'b11100; w[1] = '{data: 23'h0ABCD, ovf: 1'b0, sticky: 1'b0, range: 1'b0};
    d[2] = 20'hFFFFF; e[2] = 5'b10100; w[2] = '{data: 23'h000FF, ovf: 1'b0, sticky: 1'b1, range: 1'b0};
    d[3] = 20'h00003; e[3] = 5'b11111; w[3] = '{data: 23'h00001, ovf: 1'b0, sticky: 1'b1, range: 1'b0};
    for (int c = 0; c < 20; c++) begin
      k = (idx < 4) ? idx : 3;
      drive_cycle(idx < 4, d[k], e[k], 1'b1, w[k], acc, rdy, popped, obs);
      if (acc) idx++;
      if (popped) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL right_extra: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL right: got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (idx == 4 && sb.size() == 0) break;
    end
    n_checks++;
    if (idx != 4 || sb.size() != 0) $display("FAIL right_drain: accepted %0d want 4, pending %0d want 0", idx, sb.size());
    else n_pass++;
  endtask

  task automatic test_range();
    logic [4:0] e[3];
    beat_t w[3];
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    int idx = 0, k;
    e[0] = 5'd4;     w[0] = '{data: 23'h0ABCDE, ovf: 1'b0, sticky: 1'b0, range: 1'b1};
    e[1] = 5'b10011; w[1] = '{data: 23'h0ABCDE, ovf: 1'b0, sticky: 1'b0, range: 1'b1};
    e[2] = 5'd0;     w[2] = '{data: 23'h0ABCDE, ovf: 1'b0, sticky: 1'b0, range: 1'b0};
    for (int c = 0; c < 20; c++) begin
      k = (idx < 3) ? idx : 2;
      drive_cycle(idx < 3, 20'hABCDE, e[k], 1'b1, w[k], acc, rdy, popped, obs);
      if (acc) idx++;
      if (popped) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL range_extra: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL range: got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (idx == 3 && sb.size() == 0) break;
    end
    n_checks++;
    if (idx != 3 || sb.size() != 0) $display("FAIL range_drain: accepted %0d want 3, pending %0d want 0", idx, sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [19:0] d[6];
    logic [4:0]  e[6];
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    int idx = 0, k, pops = 0;
    for (int i = 0; i < 6; i++) begin
      d[i] = 20'(32'h11111 * (i + 1) + i);
      e[i] = 5'(i - 2);
    end
    for (int c = 0; c < 40; c++) begin
      k = (idx < 6) ? idx : 5;
      drive_cycle(idx < 6, d[k], e[k], c >= 4, model(d[k], e[k]), acc, rdy, popped, obs);
      if (acc) idx++;
      if (c == 2 || c == 3) begin
        n_checks++;
        if (rdy !== 1'b0) $display("FAIL bp_ready_low: cycle %0d got %b want 0", c, rdy);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0 || obs !== sb[0])
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h want valid=1 data=%h", c, bus.out_valid, obs.data,
                   (sb.size() > 0) ? sb[0].data : 23'h0);
        else n_pass++;
      end
      if (c >= 4 && sb.size() > 0) begin
        n_checks++;
        if (!popped) $display("FAIL bp_gap: cycle %0d got no output want one", c);
        else n_pass++;
      end
      if (popped) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL bp_extra: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL bp_order: got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (idx == 6 && sb.size() == 0) break;
    end
    n_checks++;
    if (idx != 6 || pops != 6) $display("FAIL bp_count: accepted %0d popped %0d want 6 and 6", idx, pops);
    else n_pass++;
  endtask

  task automatic test_random();
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    logic [19:0] d;
    logic [4:0] e;
    int pushes = 0, pops = 0;
    for (int c = 0; c < 10040; c++) begin
      d = 20'($urandom);
      e = 5'($urandom);
      drive_cycle((c < 10000) && ($urandom_range(0, 3) != 0), d, e,
                  (c >= 10000) || ($urandom_range(0, 3) != 0), model(d, e), acc, rdy, popped, obs);
      if (acc) pushes++;
      if (popped) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL random_extra: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL random: cycle %0d got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     c, obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (c >= 10000 && sb.size() == 0) break;
    end
    n_checks++;
    if (pushes != pops || sb.size() != 0)
      $display("FAIL random_count: popped %0d want %0d, pending %0d want 0", pops, pushes, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat_t obs, exp_b;
    logic acc, rdy, popped;
    int idx = 0, pops = 0;
    drive_cycle(1'b1, 20'h12345, 5'd1, 1'b0, model(20'h12345, 5'd1), acc, rdy, popped, obs);
    drive_cycle(1'b1, 20'h54321, 5'd2, 1'b0, model(20'h54321, 5'd2), acc, rdy, popped, obs);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL mid_preload: got valid=%b want 1", bus.out_valid);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL mid_async: got valid=%b want 0", bus.out_valid);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(idx < 2, (idx == 0) ? 20'h0F0F0 : 20'hA5A5A, 5'b11110, 1'b1,
                  model((idx == 0) ? 20'h0F0F0 : 20'hA5A5A, 5'b11110), acc, rdy, popped, obs);
      if (acc) idx++;
      if (popped) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL mid_stale: unexpected beat data=%h", obs.data);
        else begin
          exp_b = sb.pop_front();
          if (obs !== exp_b)
            $display("FAIL mid_post: got data=%h ovf=%b sticky=%b range=%b want data=%h ovf=%b sticky=%b range=%b",
                     obs.data, obs.ovf, obs.sticky, obs.range, exp_b.data, exp_b.ovf, exp_b.sticky, exp_b.range);
          else n_pass++;
        end
      end
      if (idx == 2 && sb.size() == 0) break;
    end
    n_checks++;
    if (pops != 2) $display("FAIL mid_count: popped %0d want 2", pops);
    else n_pass++;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_exp      = '0;
    bus.out_ready   = 1'b1;
    bus_n.in_valid  = 1'b0;
    bus_n.in_data   = '0;
    bus_n.in_exp    = '0;
    bus_n.out_ready = 1'b1;
    test_reset();
    test_left();
    test_left_narrow();
    test_right();
    test_range();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
